// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, FIFO to decode,
// flush/restart on redirect. Define PREFETCH_PERF_EN to add perf counters.
module prefetch_queue #(
    parameter int                      ADDRESS_BITS = 16,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    mem_req,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instruction,
    output logic [ADDRESS_BITS-1:0] out_pc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]             perf_redirects,
    output logic [15:0]             perf_starved
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(4);

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDRESS_BITS-1:0] pc_mem_q [DEPTH];
    logic [31:0]             instr_mem_q [DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           outst_q, outst_d;
    logic [CW-1:0]           discard_q, discard_d;
    logic [CW:0]             credit;
    logic [ADDRESS_BITS-1:0] redirect_base;
    logic                    issue, push, pop;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign redirect_base  = {redirect_pc[ADDRESS_BITS-1:2], 2'b00};

    // Buffered entries plus in-flight fetches may never exceed DEPTH.
    assign credit    = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req   = ~redirect & (credit < {1'b0, DEPTH_C});
    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0) & ~redirect;

    assign out_instruction = instr_mem_q[rd_ptr_q];
    assign out_pc          = pc_mem_q[rd_ptr_q];

    assign issue = mem_req & mem_gnt;
    assign push  = mem_rvalid & (discard_q == '0) & ~redirect;
    assign pop   = out_valid & out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(issue) - CW'(mem_rvalid);
        if (redirect) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Every fetch still in flight after this cycle is stale.
            discard_d  = outst_q - CW'(mem_rvalid);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + STEP;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + STEP;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (mem_rvalid && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= RESET_PC;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
                instr_mem_q[wr_ptr_q] <= mem_rdata;
            end
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_redirects_q, perf_starved_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_redirects_q <= '0;
            perf_starved_q   <= '0;
        end else begin
            if (redirect && perf_redirects_q != 16'hFFFF) begin
                perf_redirects_q <= perf_redirects_q + 16'd1;
            end
            if (out_ready && !out_valid && perf_starved_q != 16'hFFFF) begin
                perf_starved_q <= perf_starved_q + 16'd1;
            end
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_starved   = perf_starved_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: per-cycle vector table plus
// scoreboarded redirect, wrap and reset sequences against a fixed-latency memory.
module tb_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [15:0] out_pc;
`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_redirects;
    logic [15:0] perf_starved;
`endif

    prefetch_queue #(
        .ADDRESS_BITS(16),
        .DEPTH(DEPTH),
        .RESET_PC(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_redirects(perf_redirects),
        .perf_starved(perf_starved)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [15:0] a;
    } req_t;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [15:0] addr;
        bit          ov;
        logic [15:0] pc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    int          lat    = 1;
    bit          sb_on  = 1'b0;
    req_t        pend[$];
    logic [15:0] exp_q[$];
    vec_t        vecs[22];

    function automatic logic [31:0] word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        sb_on       = 1'b0;
        pend.delete();
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc_n = 0;
    endtask

    // Drive this cycle's memory response and grant; outputs settle after.
    task automatic setup();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word(pend[0].a);
            pend.delete(0);
        end
        #1;
        mem_gnt = mem_req;
        #1;
    endtask

    task automatic advance();
        if (sb_on && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop: unexpected pc %h", out_pc);
            end else begin
                chk("pop.pc", 32'(out_pc), 32'(exp_q[0]));
                chk("pop.instr", out_instruction, word(exp_q[0]));
                exp_q.delete(0);
            end
        end
        if (mem_req && mem_gnt) pend.push_back('{due: cyc_n + lat, a: mem_addr});
        chk("credit", 32'(pend.size() <= DEPTH), 32'd1);
        @(negedge clock);
        cyc_n++;
    endtask

    task automatic run_sb(input string name, input int max);
        int n;
        n     = 0;
        sb_on = 1'b1;
        while (exp_q.size() > 0 && n < max) begin
            setup();
            advance();
            n++;
        end
        chk({name, ".done"}, 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;
    endtask

    initial begin
        // 1-cycle memory, decode always ready
        vecs[0]  = '{1, 1, 1, 16'h0000, 0, 16'h0000};
        vecs[1]  = '{0, 1, 1, 16'h0004, 0, 16'h0000};
        vecs[2]  = '{0, 1, 1, 16'h0008, 1, 16'h0000};
        vecs[3]  = '{0, 1, 1, 16'h000C, 1, 16'h0004};
        vecs[4]  = '{0, 1, 1, 16'h0010, 1, 16'h0008};
        vecs[5]  = '{0, 1, 1, 16'h0014, 1, 16'h000C};
        // decode stalled 10 cycles, then released
        vecs[6]  = '{1, 0, 1, 16'h0000, 0, 16'h0000};
        vecs[7]  = '{0, 0, 1, 16'h0004, 0, 16'h0000};
        vecs[8]  = '{0, 0, 1, 16'h0008, 1, 16'h0000};
        vecs[9]  = '{0, 0, 1, 16'h000C, 1, 16'h0000};
        vecs[10] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[11] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[12] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[13] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[14] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[15] = '{0, 0, 0, 16'h0010, 1, 16'h0000};
        vecs[16] = '{0, 1, 0, 16'h0010, 1, 16'h0000};
        vecs[17] = '{0, 1, 1, 16'h0010, 1, 16'h0004};
        vecs[18] = '{0, 1, 1, 16'h0014, 1, 16'h0008};
        vecs[19] = '{0, 1, 1, 16'h0018, 1, 16'h000C};
        vecs[20] = '{0, 1, 1, 16'h001C, 1, 16'h0010};
        vecs[21] = '{0, 1, 1, 16'h0020, 1, 16'h0014};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        @(negedge clock);
        chk("rst.req", 32'(mem_req), 32'd1);
        chk("rst.addr", 32'(mem_addr), 32'h0);
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.instr", out_instruction, 32'h0);
        chk("rst.pc", 32'(out_pc), 32'h0);

        lat = 1;
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst) do_reset();
            out_ready = vecs[i].rdy;
            setup();
            chk($sformatf("v%0d.req", i), 32'(mem_req), 32'(vecs[i].req));
            chk($sformatf("v%0d.addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d.ov", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                chk($sformatf("v%0d.pc", i), 32'(out_pc), 32'(vecs[i].pc));
                chk($sformatf("v%0d.instr", i), out_instruction, word(vecs[i].pc));
            end
            advance();
        end

        // Redirect with 3 fetches in flight on a slow memory
        do_reset();
        lat       = 4;
        out_ready = 1'b1;
        repeat (3) begin
            setup();
            advance();
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0102;
        setup();
        chk("A.redir.req", 32'(mem_req), 32'd0);
        chk("A.redir.ov", 32'(out_valid), 32'd0);
        advance();
        redirect = 1'b0;
        setup();
        chk("A.req", 32'(mem_req), 32'd1);
        chk("A.addr", 32'(mem_addr), 32'h0100);
        advance();
        exp_q = '{16'h0100, 16'h0104, 16'h0108};
        run_sb("A", 40);

        // Redirect coincident with a response and out_ready
        do_reset();
        lat       = 2;
        out_ready = 1'b1;
        repeat (3) begin
            setup();
            advance();
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        setup();
        chk("B.redir.rvalid", 32'(mem_rvalid), 32'd1);
        chk("B.redir.ov", 32'(out_valid), 32'd0);
        chk("B.redir.req", 32'(mem_req), 32'd0);
        advance();
        redirect = 1'b0;
        setup();
        chk("B.addr", 32'(mem_addr), 32'h0200);
        chk("B.ov", 32'(out_valid), 32'd0);
        advance();
        exp_q = '{16'h0200, 16'h0204, 16'h0208};
        run_sb("B", 40);

        // Address wrap, low redirect bits ignored
        do_reset();
        lat         = 1;
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        setup();
        chk("C.redir.req", 32'(mem_req), 32'd0);
        advance();
        redirect = 1'b0;
        exp_q    = '{16'hFFFC, 16'h0000, 16'h0004};
        sb_on    = 1'b1;
        setup();
        chk("C.addr0", 32'(mem_addr), 32'hFFFC);
        advance();
        setup();
        chk("C.addr1", 32'(mem_addr), 32'h0000);
        advance();
        run_sb("C", 20);

        // Back-to-back redirects: last wins, discards accumulate
        do_reset();
        lat       = 4;
        out_ready = 1'b1;
        repeat (3) begin
            setup();
            advance();
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        setup();
        advance();
        redirect_pc = 16'h0400;
        setup();
        advance();
        redirect = 1'b0;
        setup();
        chk("E.req", 32'(mem_req), 32'd1);
        chk("E.addr", 32'(mem_addr), 32'h0400);
        advance();
`ifdef PREFETCH_PERF_EN
        chk("E.perf_redirects", 32'(perf_redirects), 32'd2);
`endif
        exp_q = '{16'h0400, 16'h0404};
        run_sb("E", 40);

        // Asynchronous reset with two entries buffered
        do_reset();
        lat       = 1;
        out_ready = 1'b0;
        repeat (3) begin
            setup();
            advance();
        end
        chk("D.pre.ov", 32'(out_valid), 32'd1);
        chk("D.pre.pc", 32'(out_pc), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("D.ov", 32'(out_valid), 32'd0);
        chk("D.addr", 32'(mem_addr), 32'h0);
        chk("D.instr", out_instruction, 32'h0);
        chk("D.pc", 32'(out_pc), 32'h0);
`ifdef PREFETCH_PERF_EN
        chk("D.perf_redirects", 32'(perf_redirects), 32'd0);
        chk("D.perf_starved", 32'(perf_starved), 32'd0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
